voice_allocator: RTL
====================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_CHANNELS, default 16, sets the number of synthesis voices.
REQ-002 Parameter NUM_BITS, default 32, sets the width of the tuning word and velocity slot.
REQ-003 Parameter NOTE_BITS, default 7, sets the width of the note-number tag.
REQ-004 clk  in  1  single clock; all state is updated on its rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 ev_valid  in  1  an event is present.
REQ-007 ev_ready  out  1  the allocator can accept an event.
REQ-008 ev_on  in  1  1 = note-on, 0 = note-off.
REQ-009 ev_note  in  NOTE_BITS  note-number tag.
REQ-010 ev_velocity  in  NUM_BITS  velocity word.
REQ-011 ev_car_word  in  NUM_BITS  carrier tuning word.
REQ-012 ev_mod_word  in  NUM_BITS  modulator tuning word.
REQ-013 available  in  NUM_CHANNELS  from the note-register stage; bit i = 1 means voice i is silent.
REQ-014 carrier_out  out  NUM_BITS*NUM_CHANNELS  per-voice carrier words; voice i occupies bits [i*NUM_BITS +: NUM_BITS].
REQ-015 modulator_out  out  NUM_BITS*NUM_CHANNELS  per-voice modulator words, same packing as carrier_out.
REQ-016 velocity_out  out  NUM_BITS*NUM_CHANNELS  per-voice velocity; 0 means released.
REQ-017 owned_mask  out  NUM_CHANNELS  bit i = voice i currently held by a note.
REQ-018 steal_pulse  out  1  one-cycle flag indicating that a voice was stolen.
REQ-019 miss_pulse  out  1  one-cycle flag indicating a note-off with no matching voice.

Function
REQ-020 FSM states: IDLE, SCAN, COMMIT; ev_ready = 1 only in IDLE.
REQ-021 Handshake: an event is accepted when ev_valid && ev_ready at a clock edge; all ev_* fields are latched in that cycle and are ignored at every other time.
REQ-022 A note-on with ev_velocity == 0 is handled as a note-off.
REQ-023 IDLE -> SCAN on accept, with the scan index set to 0.
REQ-024 SCAN examines one voice per cycle, index 0..NUM_CHANNELS-1, and moves to COMMIT after index NUM_CHANNELS-1; the scan therefore lasts exactly NUM_CHANNELS cycles.
REQ-025 Note-on scan records two things: the lowest-index voice where owned == 1 and the tag matches ev_note (the match), and the lowest-index voice where owned == 0 and available == 1 (the free voice).
REQ-026 Note-off scan records the lowest-index voice where owned == 1 and the tag matches ev_note.
REQ-027 Note-on COMMIT target priority is: match (retrigger), else free voice, else the voice at steal_ptr.
REQ-028 On a steal, steal_pulse = 1 for that cycle and steal_ptr increments, wrapping from NUM_CHANNELS-1 to 0; steal_ptr is unchanged otherwise.
REQ-029 Note-on COMMIT writes the carrier word, modulator word, velocity and tag into the target voice and sets owned.
REQ-030 Note-off COMMIT, when a match exists, zeroes the velocity slot and clears owned; the carrier and modulator words are retained so the release tail continues.
REQ-031 Note-off COMMIT with no match changes no voice and sets miss_pulse = 1 for one cycle.
REQ-032 COMMIT -> IDLE unconditionally.
REQ-033 Timing: an event accepted at edge T has its output buses updated at edge T+NUM_CHANNELS+1, and ev_ready is high again from that cycle.
REQ-034 Voices other than the target never change.
REQ-035 available is sampled live during SCAN; a change after the scan has passed a voice does not affect the decision.
REQ-036 Only NUM_BITS bits are stored per slot; there is no arithmetic on the words.

Reset
REQ-037 While rst = 0, the following are held at 0: all output buses, owned_mask, the tags, steal_ptr, steal_pulse, miss_pulse and ev_ready; the FSM is held in IDLE.
REQ-038 An event in SCAN or COMMIT when reset asserts is discarded with no partial write.
REQ-039 The first accept is possible at the first edge after rst returns to 1.

Verification
REQ-040 Reset, then all available = 1, note-on note=60 car=0x0100_0000 vel=0x80 -> voice 0 written at T+17, owned_mask = 0x0001, steal_pulse = 0.
REQ-041 Note-on note=60 again with vel=0x40 -> voice 0 retriggered to vel 0x40, owned_mask unchanged, no other voice touched.
REQ-042 Note-off note=60 -> velocity slot 0 = 0, carrier slot 0 still 0x0100_0000, owned_mask = 0x0000; a following note-off note=61 -> miss_pulse for exactly one cycle, no bus change.
REQ-043 17 successive note-ons with notes 0..16 -> voices 0..15 filled; the 17th steals voice 0 with steal_pulse = 1 and steal_ptr = 1; an 18th distinct note steals voice 1.
REQ-044 Note-on with vel=0 for an owned note 5 -> handled as a note-off; voice released.
REQ-045 rst asserted mid-SCAN -> all outputs 0 asynchronously; the post-reset note-on lands in voice 0.

Source files
------------

// File: rtl/voice_allocator_if.sv
// Event channel into the voice allocator: one note-on/note-off event per handshake.
// An event transfers on a rising clk edge where ev_valid && ev_ready; the source holds all ev_* fields stable while ev_valid is high and not yet accepted.
interface voice_allocator_if #(
  parameter int NUM_BITS  = 32,
  parameter int NOTE_BITS = 7
);
  logic                 ev_valid;
  logic                 ev_ready;
  logic                 ev_on;
  logic [NOTE_BITS-1:0] ev_note;
  logic [NUM_BITS-1:0]  ev_velocity;
  logic [NUM_BITS-1:0]  ev_car_word;
  logic [NUM_BITS-1:0]  ev_mod_word;

  modport master (
    output ev_valid, ev_on, ev_note, ev_velocity, ev_car_word, ev_mod_word,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_on, ev_note, ev_velocity, ev_car_word, ev_mod_word,
    output ev_ready
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: each accepted event scans every voice once, then commits
// a retrigger, a free-voice claim, a round-robin steal or a release into one voice slot.
module voice_allocator #(
  parameter int NUM_CHANNELS = 16,
  parameter int NUM_BITS     = 32,
  parameter int NOTE_BITS    = 7,
  localparam int IW          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  voice_allocator_if.slave                 ev,
  input  logic [NUM_CHANNELS-1:0]          available,
  output logic [NUM_BITS*NUM_CHANNELS-1:0] carrier_out,
  output logic [NUM_BITS*NUM_CHANNELS-1:0] modulator_out,
  output logic [NUM_BITS*NUM_CHANNELS-1:0] velocity_out,
  output logic [NUM_CHANNELS-1:0]          owned_mask,
  output logic                             steal_pulse,
  output logic                             miss_pulse,
  output logic [1:0]                       dbg_state_o,
  output logic [IW-1:0]                    dbg_steal_ptr_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2} state_t;

  localparam logic [IW-1:0] LAST = IW'(NUM_CHANNELS - 1);

  state_t state_q, state_d;

  logic                 on_q;
  logic [NOTE_BITS-1:0] note_q;
  logic [NUM_BITS-1:0]  vel_in_q, car_in_q, mod_in_q;
  logic [IW-1:0]        idx_q;
  logic                 match_hit_q, free_hit_q;
  logic [IW-1:0]        match_idx_q, free_idx_q;
  logic [IW-1:0]        steal_ptr_q;
  logic                 steal_q, miss_q;

  logic [NUM_CHANNELS-1:0] owned_q;
  logic [NUM_BITS-1:0]     car_q [NUM_CHANNELS];
  logic [NUM_BITS-1:0]     mod_q [NUM_CHANNELS];
  logic [NUM_BITS-1:0]     vel_q [NUM_CHANNELS];
  logic [NOTE_BITS-1:0]    tag_q [NUM_CHANNELS];

  logic          accept;
  logic [IW-1:0] target;
  logic          do_steal;

  // Ready is gated by reset so the channel reads not-ready while the block is held.
  assign ev.ev_ready = rst && (state_q == IDLE);
  assign accept      = ev.ev_valid && ev.ev_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SCAN;
      SCAN:    if (idx_q == LAST) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    target   = steal_ptr_q;
    do_steal = 1'b0;
    if (match_hit_q)     target = match_idx_q;
    else if (free_hit_q) target = free_idx_q;
    else                 do_steal = on_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      on_q        <= 1'b0;
      note_q      <= '0;
      vel_in_q    <= '0;
      car_in_q    <= '0;
      mod_in_q    <= '0;
      idx_q       <= '0;
      match_hit_q <= 1'b0;
      match_idx_q <= '0;
      free_hit_q  <= 1'b0;
      free_idx_q  <= '0;
      steal_ptr_q <= '0;
      steal_q     <= 1'b0;
      miss_q      <= 1'b0;
      owned_q     <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        car_q[i] <= '0;
        mod_q[i] <= '0;
        vel_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      steal_q <= 1'b0;
      miss_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            // A zero-velocity note-on is folded into a note-off here, once.
            on_q        <= ev.ev_on && (ev.ev_velocity != '0);
            note_q      <= ev.ev_note;
            vel_in_q    <= ev.ev_velocity;
            car_in_q    <= ev.ev_car_word;
            mod_in_q    <= ev.ev_mod_word;
            idx_q       <= '0;
            match_hit_q <= 1'b0;
            free_hit_q  <= 1'b0;
          end
        end
        SCAN: begin
          idx_q <= idx_q + 1'b1;
          if (!match_hit_q && owned_q[idx_q] && (tag_q[idx_q] == note_q)) begin
            match_hit_q <= 1'b1;
            match_idx_q <= idx_q;
          end
          if (!free_hit_q && !owned_q[idx_q] && available[idx_q]) begin
            free_hit_q <= 1'b1;
            free_idx_q <= idx_q;
          end
        end
        COMMIT: begin
          if (on_q) begin
            car_q[target]   <= car_in_q;
            mod_q[target]   <= mod_in_q;
            vel_q[target]   <= vel_in_q;
            tag_q[target]   <= note_q;
            owned_q[target] <= 1'b1;
            if (do_steal) begin
              steal_q     <= 1'b1;
              steal_ptr_q <= (steal_ptr_q == LAST) ? '0 : steal_ptr_q + 1'b1;
            end
          end else if (match_hit_q) begin
            // Tuning words stay put so the release tail keeps its pitch.
            vel_q[match_idx_q]   <= '0;
            owned_q[match_idx_q] <= 1'b0;
          end else begin
            miss_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    carrier_out   = '0;
    modulator_out = '0;
    velocity_out  = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      carrier_out[i*NUM_BITS +: NUM_BITS]   = car_q[i];
      modulator_out[i*NUM_BITS +: NUM_BITS] = mod_q[i];
      velocity_out[i*NUM_BITS +: NUM_BITS]  = vel_q[i];
    end
  end

  assign owned_mask      = owned_q;
  assign steal_pulse     = steal_q;
  assign miss_pulse      = miss_q;
  assign dbg_state_o     = state_q;
  assign dbg_steal_ptr_o = steal_ptr_q;

endmodule
